// File: rtl/trap_return.sv
// xRET sequencer: flush, drain, redirect fetch to xEPC, then commit status/privilege in one cycle.
// Define TRAP_RETURN_SRET_EN to add SRET support; by default every accepted xRET is an MRET.
module trap_return #(
    parameter int ILEN        = 32,
    parameter int ALEN        = 32,
    parameter int XLEN        = 32,
    parameter int HAS_UMODE   = 1,
    parameter int DRAIN_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   xret_valid,
    input  logic [ILEN-1:0]        xret_instr,
    input  logic [1:0]             cur_priv,
    input  logic [ALEN-1:0]        mepc,
    input  logic                   mstatus_mpie,
    input  logic [1:0]             mstatus_mpp,
    input  logic                   trap_valid,
    input  logic                   pipe_drained,
    input  logic                   fetch_redirect_ready,
`ifdef TRAP_RETURN_SRET_EN
    input  logic                   xret_is_sret,
    input  logic [ALEN-1:0]        sepc,
    input  logic                   sstatus_spie,
    input  logic                   sstatus_spp,
    input  logic                   mstatus_tsr,
`endif
    output logic                   xret_busy,
    output logic                   flush,
    output logic                   fetch_redirect_valid,
    output logic [ALEN-1:0]        fetch_redirect_target,
    output logic                   csr_status_we,
    output logic                   csr_xie_new,
    output logic                   csr_xpie_new,
    output logic [1:0]             csr_xpp_new,
    output logic                   priv_we,
    output logic [1:0]             priv_new,
    output logic                   illegal_valid,
    output logic [XLEN-1:0]        illegal_mtval,
    output logic [DRAIN_CNT_W-1:0] drain_cycles
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        REDIRECT,
        COMMIT
    } state_t;

    localparam logic [1:0]      MRET_XPP    = (HAS_UMODE != 0) ? 2'b00 : 2'b11;
    localparam logic [ALEN-1:0] TARGET_MASK = {{(ALEN-2){1'b1}}, 2'b00};

    state_t                 state_q, state_d;
    logic [ALEN-1:0]        target_q, target_d;
    logic                   pie_q, pie_d;
    logic [1:0]             pp_q, pp_d;
    logic [1:0]             xpp_q, xpp_d;
    logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;
    logic [DRAIN_CNT_W-1:0] drain_cycles_q, drain_cycles_d;
    logic                   flush_q, flush_d;
    logic                   illegal_valid_q, illegal_valid_d;
    logic [XLEN-1:0]        illegal_mtval_q, illegal_mtval_d;

    logic                   sel_legal;
    logic [ALEN-1:0]        sel_epc;
    logic                   sel_pie;
    logic [1:0]             sel_pp;
    logic [1:0]             sel_xpp;

    // Source selection for the request in IDLE; MPP=10 is reserved and returns to M.
    always_comb begin
        sel_legal = (cur_priv == 2'b11);
        sel_epc   = mepc;
        sel_pie   = mstatus_mpie;
        sel_pp    = (mstatus_mpp == 2'b10) ? 2'b11 : mstatus_mpp;
        sel_xpp   = MRET_XPP;
`ifdef TRAP_RETURN_SRET_EN
        if (xret_is_sret) begin
            sel_legal = (cur_priv == 2'b11) || ((cur_priv == 2'b01) && !mstatus_tsr);
            sel_epc   = sepc;
            sel_pie   = sstatus_spie;
            sel_pp    = {1'b0, sstatus_spp};
            sel_xpp   = 2'b00;
        end
`endif
    end

    always_comb begin
        state_d         = state_q;
        target_d        = target_q;
        pie_d           = pie_q;
        pp_d            = pp_q;
        xpp_d           = xpp_q;
        cnt_d           = cnt_q;
        drain_cycles_d  = drain_cycles_q;
        flush_d         = 1'b0;
        illegal_valid_d = 1'b0;
        illegal_mtval_d = illegal_mtval_q;

        case (state_q)
            IDLE: begin
                if (xret_valid && !trap_valid) begin
                    if (sel_legal) begin
                        target_d = sel_epc & TARGET_MASK;
                        pie_d    = sel_pie;
                        pp_d     = sel_pp;
                        xpp_d    = sel_xpp;
                        cnt_d    = '0;
                        flush_d  = 1'b1;
                        state_d  = DRAIN;
                    end else begin
                        illegal_valid_d = 1'b1;
                        illegal_mtval_d = XLEN'(xret_instr);
                    end
                end
            end
            DRAIN: begin
                // The current cycle counts, so a one-cycle drain reports 1.
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + DRAIN_CNT_W'(1);
                if (trap_valid) begin
                    state_d = IDLE;
                end else if (pipe_drained) begin
                    drain_cycles_d = cnt_d;
                    state_d        = REDIRECT;
                end
            end
            REDIRECT: begin
                if (fetch_redirect_ready) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            target_q        <= '0;
            pie_q           <= 1'b0;
            pp_q            <= 2'b00;
            xpp_q           <= 2'b00;
            cnt_q           <= '0;
            drain_cycles_q  <= '0;
            flush_q         <= 1'b0;
            illegal_valid_q <= 1'b0;
            illegal_mtval_q <= '0;
        end else begin
            state_q         <= state_d;
            target_q        <= target_d;
            pie_q           <= pie_d;
            pp_q            <= pp_d;
            xpp_q           <= xpp_d;
            cnt_q           <= cnt_d;
            drain_cycles_q  <= drain_cycles_d;
            flush_q         <= flush_d;
            illegal_valid_q <= illegal_valid_d;
            illegal_mtval_q <= illegal_mtval_d;
        end
    end

    // CSR and privilege data are gated to COMMIT so nothing leaks on other cycles.
    assign xret_busy             = (state_q != IDLE);
    assign flush                 = flush_q;
    assign fetch_redirect_valid  = (state_q == REDIRECT);
    assign fetch_redirect_target = target_q;
    assign csr_status_we         = (state_q == COMMIT);
    assign csr_xie_new           = (state_q == COMMIT) && pie_q;
    assign csr_xpie_new          = (state_q == COMMIT);
    assign csr_xpp_new           = (state_q == COMMIT) ? xpp_q : 2'b00;
    assign priv_we               = (state_q == COMMIT);
    assign priv_new              = (state_q == COMMIT) ? pp_q : 2'b00;
    assign illegal_valid         = illegal_valid_q;
    assign illegal_mtval         = illegal_mtval_q;
    assign drain_cycles          = drain_cycles_q;

endmodule

// File: tb/tb_trap_return.sv
// Scoreboard bench for trap_return: expected flush/illegal/redirect/commit events are queued
// with the cycle they must appear in, and a negedge monitor pops and compares them.
module tb_trap_return;

    localparam int K_FLUSH  = 1;
    localparam int K_ILL    = 2;
    localparam int K_REDIR  = 3;
    localparam int K_COMMIT = 4;

    typedef struct {
        int          kind;
        int          cyc;
        logic [63:0] data;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        xret_valid;
    logic [31:0] xret_instr;
    logic [1:0]  cur_priv;
    logic [31:0] mepc;
    logic        mstatus_mpie;
    logic [1:0]  mstatus_mpp;
    logic        trap_valid;
    logic        pipe_drained;
    logic        fetch_redirect_ready;
    logic        xret_busy;
    logic        flush;
    logic        fetch_redirect_valid;
    logic [31:0] fetch_redirect_target;
    logic        csr_status_we;
    logic        csr_xie_new;
    logic        csr_xpie_new;
    logic [1:0]  csr_xpp_new;
    logic        priv_we;
    logic [1:0]  priv_new;
    logic        illegal_valid;
    logic [31:0] illegal_mtval;
    logic [7:0]  drain_cycles;

    int       cyc = 0;
    int       checks = 0;
    int       errors = 0;
    sb_item_t sb[$];

    trap_return #(
        .ILEN(32), .ALEN(32), .XLEN(32), .HAS_UMODE(1), .DRAIN_CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .xret_valid(xret_valid),
        .xret_instr(xret_instr),
        .cur_priv(cur_priv),
        .mepc(mepc),
        .mstatus_mpie(mstatus_mpie),
        .mstatus_mpp(mstatus_mpp),
        .trap_valid(trap_valid),
        .pipe_drained(pipe_drained),
        .fetch_redirect_ready(fetch_redirect_ready),
        .xret_busy(xret_busy),
        .flush(flush),
        .fetch_redirect_valid(fetch_redirect_valid),
        .fetch_redirect_target(fetch_redirect_target),
        .csr_status_we(csr_status_we),
        .csr_xie_new(csr_xie_new),
        .csr_xpie_new(csr_xpie_new),
        .csr_xpp_new(csr_xpp_new),
        .priv_we(priv_we),
        .priv_new(priv_new),
        .illegal_valid(illegal_valid),
        .illegal_mtval(illegal_mtval),
        .drain_cycles(drain_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic popCheck(input int kind, input string tag, input logic [63:0] data);
        sb_item_t e;
        checkOutput({tag, "_expected"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput({tag, "_kind"}, 64'(kind), 64'(e.kind));
            checkOutput({tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
            checkOutput({tag, "_data"}, data, e.data);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 64'(xret_busy), 64'd0);
        checkOutput({tag, "_flush"}, 64'(flush), 64'd0);
        checkOutput({tag, "_rvalid"}, 64'(fetch_redirect_valid), 64'd0);
        checkOutput({tag, "_target"}, 64'(fetch_redirect_target), 64'd0);
        checkOutput({tag, "_strobes"}, 64'({csr_status_we, priv_we, illegal_valid}), 64'd0);
        checkOutput({tag, "_csrdata"}, 64'({csr_xie_new, csr_xpie_new, csr_xpp_new, priv_new}), 64'd0);
        checkOutput({tag, "_mtval"}, 64'(illegal_mtval), 64'd0);
        checkOutput({tag, "_drain"}, 64'(drain_cycles), 64'd0);
    endtask

    // Monitor: every active output event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (flush) popCheck(K_FLUSH, "flush", 64'd0);
            if (illegal_valid) popCheck(K_ILL, "illegal", 64'(illegal_mtval));
            if (fetch_redirect_valid) begin
                if (sb.size() != 0 && sb[0].kind == K_REDIR)
                    checkOutput("redirect_hold", 64'(fetch_redirect_target), sb[0].data);
                if (fetch_redirect_ready) popCheck(K_REDIR, "redirect", 64'(fetch_redirect_target));
            end
            if (csr_status_we || priv_we)
                popCheck(K_COMMIT, "commit", {48'd0, drain_cycles, csr_status_we, priv_we,
                                              csr_xie_new, csr_xpie_new, csr_xpp_new, priv_new});
        end
    end

    // One xRET attempt: d cycles of pipe_drained low, r cycles of ready low in REDIRECT,
    // optional trap at DRAIN offset trap_k, optional reset at offset rst_k.
    task automatic applyStimulus(input logic [31:0] pc, input logic pie, input logic [1:0] pp,
                                 input logic [1:0] priv, input logic [31:0] instr,
                                 input logic trap_in_idle, input int d, input int r,
                                 input int trap_k, input int rst_k);
        int         a;
        int         dc;
        logic [1:0] pnew;
        @(posedge clk); #1;
        mepc         = pc;
        mstatus_mpie = pie;
        mstatus_mpp  = pp;
        cur_priv     = priv;
        xret_instr   = instr;
        xret_valid   = 1'b1;
        trap_valid   = trap_in_idle;
        pipe_drained = 1'b0;
        fetch_redirect_ready = 1'b0;
        a    = cyc + 1;
        pnew = (pp == 2'b10) ? 2'b11 : pp;
        dc   = (d + 1 > 255) ? 255 : d + 1;
        if (!trap_in_idle) begin
            if (priv != 2'b11) begin
                sb.push_back('{K_ILL, a, 64'(instr)});
            end else begin
                sb.push_back('{K_FLUSH, a, 64'd0});
                if (trap_k < 0) begin
                    sb.push_back('{K_REDIR, a + d + 1 + r, 64'(pc & 32'hFFFF_FFFC)});
                    sb.push_back('{K_COMMIT, a + d + 2 + r,
                                   {48'd0, 8'(dc), 1'b1, 1'b1, pie, 1'b1, 2'b00, pnew}});
                end
            end
        end
        @(posedge clk); #1;
        xret_valid = 1'b0;
        trap_valid = 1'b0;
        for (int k = 0; k < d + r + 4; k++) begin
            pipe_drained         = (k >= d);
            fetch_redirect_ready = (k >= d + 1 + r);
            trap_valid           = (k == trap_k);
            if (k == rst_k) begin
                #1 rst = 1'b0;
                #1 checkAllZero("midreset");
                sb.delete();
            end
            @(posedge clk); #1;
        end
        pipe_drained         = 1'b0;
        fetch_redirect_ready = 1'b0;
        trap_valid           = 1'b0;
        rst                  = 1'b1;
        @(posedge clk); #1;
        checkOutput("busy_end", 64'(xret_busy), 64'd0);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        xret_valid = 1'b0; xret_instr = '0; cur_priv = 2'b11; mepc = '0;
        mstatus_mpie = 1'b0; mstatus_mpp = 2'b00; trap_valid = 1'b0;
        pipe_drained = 1'b0; fetch_redirect_ready = 1'b0;
        #12;
        checkAllZero("reset");
        @(posedge clk); #1 rst = 1'b1;

        $display("[TB] basic MRET");
        applyStimulus(32'h8000_0104, 1'b1, 2'b00, 2'b11, 32'h3020_0073, 1'b0, 0, 0, -1, -1);
        $display("[TB] slow drain and slow fetch");
        applyStimulus(32'h8000_0104, 1'b1, 2'b00, 2'b11, 32'h3020_0073, 1'b0, 5, 3, -1, -1);
        $display("[TB] illegal MRET from U-mode");
        applyStimulus(32'h8000_0104, 1'b1, 2'b00, 2'b00, 32'h3020_0073, 1'b0, 0, 0, -1, -1);
        $display("[TB] trap wins over xRET in IDLE");
        applyStimulus(32'h8000_0200, 1'b1, 2'b11, 2'b11, 32'h3020_0073, 1'b1, 0, 0, -1, -1);
        $display("[TB] trap in second DRAIN cycle");
        applyStimulus(32'h8000_0300, 1'b1, 2'b01, 2'b11, 32'h3020_0073, 1'b0, 4, 0, 1, -1);
        $display("[TB] misaligned mepc and reserved MPP");
        applyStimulus(32'h8000_0107, 1'b0, 2'b10, 2'b11, 32'h3020_0073, 1'b0, 1, 0, -1, -1);
        $display("[TB] reset during REDIRECT");
        applyStimulus(32'h8000_0400, 1'b1, 2'b00, 2'b11, 32'h3020_0073, 1'b0, 0, 5, -1, 2);
        $display("[TB] normal xRET after reset");
        applyStimulus(32'h0000_2000, 1'b1, 2'b01, 2'b11, 32'h3020_0073, 1'b0, 2, 1, -1, -1);
        $display("[TB] drain counter saturation");
        applyStimulus(32'h0000_4008, 1'b0, 2'b11, 2'b11, 32'h3020_0073, 1'b0, 300, 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
